// File: rtl/iq_decimator.sv
// -----------------------------------------------------------------------------
// iq_decimator
//
// Accumulate-and-dump decimating low-pass for the mixer I/Q outputs. Sums
// N = 2^d consecutive valid I/Q samples and emits the rounded (half up),
// saturated average. It sits between the mixer and the demodulators.
//
// Optional feature macro: MAG_EST_EN
//   defined   -> adds mag_out = max(|I|,|Q|) + min(|I|,|Q|)/2, computed from
//                the saturated result. One extra pipeline register is added,
//                so results appear two cycles after the dumping sample.
//   undefined -> no mag_out port. Results appear one cycle after the dump.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   in_valid   in   qualifies i_in/q_in this cycle
//   i_in       in   signed I sample (IN_W)
//   q_in       in   signed Q sample (IN_W)
//   dec_log2   in   log2 decimation ratio. Values above DEC_MAX_LOG2 are clamped.
//   out_ready  in   downstream accepts i_out/q_out
//   out_valid  out  i_out/q_out hold a result
//   i_out      out  signed decimated I (OUT_W)
//   q_out      out  signed decimated Q (OUT_W)
//   overrun    out  sticky: an unconsumed result was overwritten
//   mag_out    out  magnitude estimate (OUT_W, unsigned). Present only with MAG_EST_EN.
//
// Output handshake: a result is transferred in any cycle where out_valid and
// out_ready are both high. While out_valid && !out_ready the outputs are held
// unless a new result arrives. In that case the new result overwrites the
// held one and overrun is set. A new result that arrives in the same cycle
// as an acceptance is loaded, and out_valid stays high.
// -----------------------------------------------------------------------------
module iq_decimator #(
    parameter int IN_W         = 16,
    parameter int OUT_W        = 16,
    parameter int DEC_MAX_LOG2 = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  i_in,
    input  logic signed [IN_W-1:0]  q_in,
    input  logic [3:0]              dec_log2,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic                    overrun
`ifdef MAG_EST_EN
    ,
    output logic [OUT_W-1:0]        mag_out
`endif
);

    localparam int ACC_W = IN_W + DEC_MAX_LOG2;
    localparam int CNT_W = DEC_MAX_LOG2 + 1;
    localparam logic [3:0] D_MAX = 4'(DEC_MAX_LOG2);

    // Saturation bounds in the widened (ACC_W+1) rounding domain.
    localparam logic signed [ACC_W:0] OUT_MAX =
        {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN =
        {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    // ACC: collecting a window. DUMP: this cycle carries the last sample.
    typedef enum logic {ST_ACC, ST_DUMP} state_t;
    state_t state;

    logic [3:0]              d;
    logic [3:0]              d_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        last_cnt;
    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic signed [ACC_W-1:0] sum_i, sum_q;
    logic signed [OUT_W-1:0] res_i, res_q;
    logic                    dump;

    // Round half up by adding 2^(d-1) before an arithmetic shift. The sum is
    // widened by one bit so the rounding offset cannot overflow.
    function automatic logic signed [OUT_W-1:0] round_sat(
        input logic signed [ACC_W-1:0] s,
        input logic [3:0]              sh
    );
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] shifted;
        ext     = {s[ACC_W-1], s};
        rnd     = ({{ACC_W{1'b0}}, 1'b1} << sh) >> 1;   // 0 when sh == 0
        shifted = (ext + rnd) >>> sh;
        if (shifted > OUT_MAX)
            return OUT_MAX[OUT_W-1:0];
        else if (shifted < OUT_MIN)
            return OUT_MIN[OUT_W-1:0];
        else
            return shifted[OUT_W-1:0];
    endfunction

    always_comb begin
        d_next   = (dec_log2 > D_MAX) ? D_MAX : dec_log2;
        last_cnt = (CNT_W'(1) << d) - CNT_W'(1);
        sum_i    = acc_i + {{DEC_MAX_LOG2{i_in[IN_W-1]}}, i_in};
        sum_q    = acc_q + {{DEC_MAX_LOG2{q_in[IN_W-1]}}, q_in};
        state    = (in_valid && (cnt == last_cnt)) ? ST_DUMP : ST_ACC;
        dump     = (state == ST_DUMP);
        res_i    = round_sat(sum_i, d);
        res_q    = round_sat(sum_q, d);
    end

    // Window accumulation. The ratio is re-latched only at a window boundary
    // or in reset, so a mid-window change of dec_log2 applies to the next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
            d     <= d_next;
        end else if (in_valid) begin
            if (dump) begin
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
                d     <= d_next;
            end else begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

    logic                    load;
    logic signed [OUT_W-1:0] load_i, load_q;

`ifdef MAG_EST_EN
    logic                    s1_valid;
    logic signed [OUT_W-1:0] s1_i, s1_q;
    logic signed [OUT_W:0]   ext_i, ext_q;
    logic [OUT_W:0]          abs_i, abs_q, mx, mn;
    logic [OUT_W+1:0]        mag_sum;
    logic [OUT_W-1:0]        mag_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_i     <= '0;
            s1_q     <= '0;
        end else begin
            s1_valid <= dump;
            if (dump) begin
                s1_i <= res_i;
                s1_q <= res_q;
            end
        end
    end

    // |-2^(OUT_W-1)| needs OUT_W+1 bits, so the magnitudes are one bit wider.
    always_comb begin
        ext_i   = {s1_i[OUT_W-1], s1_i};
        ext_q   = {s1_q[OUT_W-1], s1_q};
        abs_i   = ext_i[OUT_W] ? -ext_i : ext_i;
        abs_q   = ext_q[OUT_W] ? -ext_q : ext_q;
        mx      = (abs_i > abs_q) ? abs_i : abs_q;
        mn      = (abs_i > abs_q) ? abs_q : abs_i;
        mag_sum = {1'b0, mx} + {2'b00, mn[OUT_W:1]};
        mag_sat = (|mag_sum[OUT_W+1:OUT_W]) ? '1 : mag_sum[OUT_W-1:0];
        load    = s1_valid;
        load_i  = s1_i;
        load_q  = s1_q;
    end
`else
    always_comb begin
        load   = dump;
        load_i = res_i;
        load_q = res_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            overrun   <= 1'b0;
`ifdef MAG_EST_EN
            mag_out   <= '0;
`endif
        end else if (load) begin
            out_valid <= 1'b1;
            i_out     <= load_i;
            q_out     <= load_q;
`ifdef MAG_EST_EN
            mag_out   <= mag_sat;
`endif
            if (out_valid && !out_ready)
                overrun <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iq_decimator.sv
// -----------------------------------------------------------------------------
// tb_iq_decimator
//
// Self-checking bench for iq_decimator: a table of window vectors, directed
// multi-cycle sequences (valid gaps, overrun/hold, mid-window ratio change,
// reset discarding a partial window), and random traffic scored against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_iq_decimator;

`ifdef MAG_EST_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] i_in = '0;
    logic signed [15:0] q_in = '0;
    logic [3:0]         dec_log2 = '0;
    logic               out_ready = 1'b1;
    logic               out_valid;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;
    logic               overrun;
`ifdef MAG_EST_EN
    logic [15:0]        mag_out;
`endif

    iq_decimator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .i_in      (i_in),
        .q_in      (q_in),
        .dec_log2  (dec_log2),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .i_out     (i_out),
        .q_out     (q_out),
        .overrun   (overrun)
`ifdef MAG_EST_EN
        ,
        .mag_out   (mag_out)
`endif
    );

    // clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input longint i, input longint q);
        in_valid = 1'b1;
        i_in     = 16'(i);
        q_in     = 16'(q);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int dec);
        dec_log2 = 4'(dec);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
    endtask

    // Reference arithmetic
    function automatic int clamp_d(input int dec);
        return (dec > 8) ? 8 : dec;
    endfunction

    function automatic longint model_result(input longint sum, input int d);
        longint n, t, r;
        n = longint'(1) << d;
        t = sum + n / 2;
        r = t / n;
        if (t < 0 && (t % n) != 0) r = r - 1;   // floor division
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic longint mag_of(input longint i, input longint q);
        longint ai, aq, mx, mn, m;
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;
        m  = mx + mn / 2;
        return (m > 65535) ? 65535 : m;
    endfunction

    typedef struct {
        int dec;
        int i0;
        int istep;
        int q0;
        int qstep;
        int exp_i;
        int exp_q;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    initial begin
        int n;
        bit early;
        int cur_d, cnt;
        longint si, sq;
        logic [31:0] e;

        vecs[0] = '{2, 100, 1, -4, 0, 102, -4};
        vecs[1] = '{3, 32767, 0, -32768, 0, 32767, -32768};
        vecs[2] = '{0, 300, 0, -400, 0, 300, -400};
        vecs[3] = '{1, 5, 1, -5, -1, 6, -5};
        vecs[4] = '{2, -1, -1, 0, 3, -2, 5};
        vecs[5] = '{8, -32768, 0, 32767, 0, -32768, 32767};
        vecs[6] = '{15, 4, 0, -3, 0, 4, -3};
        vecs[7] = '{0, -32768, 0, -32768, 0, -32768, -32768};

        // ---- reset state ----
        do_reset(vecs[0].dec);
        check("rst_valid", out_valid, 0);
        check("rst_i", i_out, 0);
        check("rst_q", q_out, 0);
        check("rst_overrun", overrun, 0);
`ifdef MAG_EST_EN
        check("rst_mag", mag_out, 0);
`endif

        // ---- table vectors ----
        // The next vector's ratio is presented with the last sample, because
        // the ratio latches at the window boundary.
        out_ready = 1'b1;
        for (int v = 0; v < NV; v++) begin
            n = 1 << clamp_d(vecs[v].dec);
            early = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (k == n - 1 && v + 1 < NV) dec_log2 = 4'(vecs[v + 1].dec);
                send(vecs[v].i0 + k * vecs[v].istep, vecs[v].q0 + k * vecs[v].qstep);
                if (k < n - 1 && out_valid) early = 1'b1;
            end
            check($sformatf("vec%0d_early", v), early, 0);
            idle(LAT - 1);
            check($sformatf("vec%0d_valid", v), out_valid, 1);
            check($sformatf("vec%0d_i", v), i_out, vecs[v].exp_i);
            check($sformatf("vec%0d_q", v), q_out, vecs[v].exp_q);
            check($sformatf("vec%0d_overrun", v), overrun, 0);
`ifdef MAG_EST_EN
            check($sformatf("vec%0d_mag", v), mag_out, mag_of(vecs[v].exp_i, vecs[v].exp_q));
`endif
            idle(1);
            check($sformatf("vec%0d_consumed", v), out_valid, 0);
        end

        // ---- valid gaps: dump only on the 4th valid sample ----
        do_reset(2);
        early = 1'b0;
        for (int k = 0; k < 7; k++) begin
            in_valid = (k % 2 == 0);
            i_in = 16'sd8;
            q_in = 16'sd0;
            tick();
            if (k < 6 && out_valid) early = 1'b1;
        end
        in_valid = 1'b0;
        check("gap_early", early, 0);
        idle(LAT - 1);
        check("gap_valid", out_valid, 1);
        check("gap_i", i_out, 8);
        check("gap_q", q_out, 0);

        // ---- hold, overrun, dump+accept in the same cycle ----
        do_reset(1);
        out_ready = 1'b0;
        send(10, -10);
        send(20, -20);
        idle(LAT - 1);
        check("ovr_first_valid", out_valid, 1);
        check("ovr_first_i", i_out, 15);
        check("ovr_first_q", q_out, -15);
        check("ovr_first_flag", overrun, 0);
        send(30, 0);
        idle(LAT - 1);
        check("ovr_hold_i", i_out, 15);
        check("ovr_hold_flag", overrun, 0);
        send(40, 0);
        idle(LAT - 1);
        check("ovr_second_i", i_out, 35);
        check("ovr_second_valid", out_valid, 1);
        check("ovr_second_flag", overrun, 1);
        send(50, 0);
        if (LAT == 1) out_ready = 1'b1;
        send(60, 0);
        out_ready = 1'b1;
        idle(LAT - 1);
        check("simul_valid", out_valid, 1);
        check("simul_i", i_out, 55);
        idle(1);
        check("simul_drained", out_valid, 0);
        check("ovr_sticky", overrun, 1);

        // ---- mid-window ratio change, reset discards a partial window ----
        do_reset(2);
        send(4, 1);
        send(4, 1);
        dec_log2 = 4'd4;
        send(4, 1);
        send(4, 1);
        idle(LAT - 1);
        check("chg_valid", out_valid, 1);
        check("chg_i", i_out, 4);
        check("chg_q", q_out, 1);
        dec_log2 = 4'd1;
        send(100, 100);
        send(100, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_valid", out_valid, 0);
        check("rst2_i", i_out, 0);
        check("rst2_q", q_out, 0);
        check("rst2_overrun", overrun, 0);
        send(6, 0);
        idle(LAT);
        check("partial_discarded", out_valid, 0);
        send(8, 0);
        idle(LAT - 1);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_i", i_out, 7);

        // ---- random traffic against the reference model ----
        cur_d = $urandom_range(0, 4);
        do_reset(cur_d);
        cur_d = clamp_d(cur_d);
        cnt = 0;
        si = 0;
        sq = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0)
                dec_log2 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15))
                                                       : 4'($urandom_range(0, 4));
            in_valid = ($urandom_range(0, 3) != 0);
            i_in = 16'($urandom_range(0, 65535));
            q_in = 16'($urandom_range(0, 65535));
            if (in_valid) begin
                si += longint'(i_in);
                sq += longint'(q_in);
                cnt++;
                if (cnt == (1 << cur_d)) begin
                    exp_q.push_back({16'(model_result(si, cur_d)), 16'(model_result(sq, cur_d))});
                    cnt = 0;
                    si = 0;
                    sq = 0;
                    cur_d = clamp_d(int'(dec_log2));
                end
            end
            tick();
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_i", i_out, longint'($signed(e[31:16])));
                    check("rand_q", q_out, longint'($signed(e[15:0])));
`ifdef MAG_EST_EN
                    check("rand_mag", mag_out,
                          mag_of(longint'($signed(e[31:16])), longint'($signed(e[15:0]))));
`endif
                end
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("drain_spurious_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("drain_i", i_out, longint'($signed(e[31:16])));
                    check("drain_q", q_out, longint'($signed(e[15:0])));
                end
            end
        end
        check("rand_missing_results", exp_q.size(), 0);
        check("rand_overrun", overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
